// File: rtl/pim_pkg.sv
// Shared types and frame-geometry helpers for the kernel serializer.
// Frame length is kernal*kernal bits.
package pim_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    function automatic int frame_len(input int k);
        return k * k;
    endfunction

    // Wide enough to hold 0..N
    function automatic int idx_w(input int k);
        return $clog2(k * k + 1);
    endfunction

endpackage

// File: rtl/kernel_hold_buf.sv
// One-deep holding buffer that queues the next kernel word.
// The buffer is loaded while the current frame shifts, and drained into the shift register.
module kernel_hold_buf #(
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         drain_i,
    input  logic [N-1:0] data_i,
    output logic [N-1:0] data_o,
    output logic         valid_o
);

    logic [N-1:0] data_q;
    logic         valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/kernel_serializer.sv
// Serializes a kernal*kernal-bit word LSB first with a valid/ready handshake.
// A one-deep buffer lets back-to-back frames stream with no bubble cycle.
module kernel_serializer
    import pim_pkg::*;
#(
    parameter int kernal = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [frame_len(kernal)-1:0]  in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          out_bit,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_first,
    output logic                          out_last,
    output logic [idx_w(kernal)-1:0]      out_idx
);

    localparam int N = frame_len(kernal);
    localparam int W = idx_w(kernal);
    localparam logic [W-1:0] LAST = W'(N - 1);

    ser_state_e   state_q, state_d;
    logic [N-1:0] sr_q, sr_d;
    logic [W-1:0] idx_q, idx_d;

    logic [N-1:0] hb_data;
    logic         hb_valid;
    logic         hb_load;
    logic         hb_drain;

    logic accept;
    logic xfer;
    logic at_last;

    kernel_hold_buf #(
        .N(N)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load_i  (hb_load),
        .drain_i (hb_drain),
        .data_i  (in_data),
        .data_o  (hb_data),
        .valid_o (hb_valid)
    );

    assign in_ready  = ~hb_valid;
    assign out_valid = (state_q == SHIFT);
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;
    assign at_last   = (idx_q == LAST);

    assign out_bit   = sr_q[0] & out_valid;
    assign out_idx   = idx_q;
    assign out_first = out_valid & (idx_q == '0);
    assign out_last  = out_valid & at_last;

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        idx_d    = idx_q;
        hb_load  = 1'b0;
        hb_drain = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = in_data;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer && !at_last) begin
                    sr_d  = sr_q >> 1;
                    idx_d = idx_q + W'(1);
                end else if (xfer && hb_valid) begin
                    sr_d     = hb_data;
                    idx_d    = '0;
                    hb_drain = 1'b1;
                end else if (xfer && accept) begin
                    sr_d  = in_data;
                    idx_d = '0;
                end else if (xfer) begin
                    sr_d    = '0;
                    idx_d   = '0;
                    state_d = IDLE;
                end
                // Mid-frame accepts queue behind the active frame
                if (accept && !(xfer && at_last)) begin
                    hb_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_kernel_serializer.sv
// Directed bench for kernel_serializer with kernal=3 (9-bit frames).
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_kernel_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_ready;
    logic       out_first;
    logic       out_last;
    logic [3:0] out_idx;

    int npass  = 0;
    int ntotal = 0;

    kernel_serializer #(
        .kernal(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_beat(input string tag, input logic b,
                            input int idx);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".bit"}, 32'(out_bit), 32'(b));
        chk({tag, ".idx"}, 32'(out_idx), 32'(idx));
        chk({tag, ".first"}, 32'(out_first), 32'(idx == 0));
        chk({tag, ".last"}, 32'(out_last), 32'(idx == 8));
    endtask

    initial begin
        logic [8:0]  w;
        logic [17:0] s2;
        logic [26:0] s3;
        rst       = 1'b0;
        in_data   = 9'h000;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.bit", 32'(out_bit), 32'd0);
        chk("rst.first", 32'(out_first), 32'd0);
        chk("rst.last", 32'(out_last), 32'd0);
        chk("rst.idx", 32'(out_idx), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        rst = 1'b1;

        // Single frame, MSB set: eight zeros then a one
        w        = 9'h100;
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk_beat($sformatf("f1.b%0d", i), w[i], i);
            tick();
        end
        chk("f1.end_valid", 32'(out_valid), 32'd0);

        // Back-to-back frames, no bubble
        s2       = {9'h15A, 9'h0A5};
        in_data  = 9'h0A5;
        in_valid = 1'b1;
        tick();
        for (int j = 0; j < 18; j++) begin
            chk_beat($sformatf("f2.b%0d", j), s2[j], j % 9);
            if (j == 0) begin
                in_data  = 9'h15A;
                in_valid = 1'b1;
            end else begin
                in_data  = 9'h1C3;
                in_valid = 1'b0;
            end
            if (j == 1) chk("f2.in_ready_full", 32'(in_ready), 32'd0);
            tick();
        end
        chk("f2.end_valid", 32'(out_valid), 32'd0);
        chk("f2.end_in_ready", 32'(in_ready), 32'd1);

        // Stall with out_ready low for frame cycles 3..6
        in_data  = 9'h1FF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        begin
            int ntx;
            ntx = 0;
            for (int c = 0; c < 13; c++) begin
                out_ready = !(c >= 3 && c <= 6);
                chk_beat($sformatf("f3.c%0d", c), 1'b1, ntx);
                chk($sformatf("f3.c%0d.in_ready", c), 32'(in_ready), 32'd1);
                if (out_ready) ntx++;
                tick();
            end
        end
        out_ready = 1'b1;
        chk("f3.end_valid", 32'(out_valid), 32'd0);

        // Three words: C must wait for B to leave the buffer
        s3       = {9'h155, 9'h0F0, 9'h003};
        in_data  = 9'h003;
        in_valid = 1'b1;
        tick();
        for (int j = 0; j < 27; j++) begin
            logic er;
            chk_beat($sformatf("f4.b%0d", j), s3[j], j % 9);
            er = (j == 0) || (j == 9) || (j >= 18);
            chk($sformatf("f4.b%0d.in_ready", j), 32'(in_ready), 32'(er));
            in_valid = (j <= 9);
            in_data  = (j == 0) ? 9'h0F0 : 9'h155;
            tick();
        end
        in_valid = 1'b0;
        chk("f4.end_valid", 32'(out_valid), 32'd0);

        // Reset mid-frame at idx 4
        in_data  = 9'h1FF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("f5.pre_idx", 32'(out_idx), 32'd4);
        rst = 1'b0;
        #1;
        chk("f5.rst_valid", 32'(out_valid), 32'd0);
        chk("f5.rst_idx", 32'(out_idx), 32'd0);
        chk("f5.rst_bit", 32'(out_bit), 32'd0);
        chk("f5.rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("f5.idle_valid", 32'(out_valid), 32'd0);
        w        = 9'h001;
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk_beat($sformatf("f5.b%0d", i), w[i], i);
            tick();
        end
        chk("f5.end_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/kernel_serializer.md
KERNEL_SERIALIZER -- requirements
Module: kernel_serializer

Interface
REQ-001 Parameter: kernal, default 3, kernel edge length; frame length N = kernal*kernal bits, N >= 1.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-low: asserted when 0.
REQ-004 Port: in_data  input  N  parallel kernel word; bit i is kernel element i.
REQ-005 Port: in_valid  input  1  in_data is offered.
REQ-006 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-007 Port: out_bit  output  1  serial bit, driven to the shift_adder in input.
REQ-008 Port: out_valid  output  1  out_bit is meaningful.
REQ-009 Port: out_ready  input  1  downstream consumes out_bit this cycle.
REQ-010 Port: out_first  output  1  out_bit is element 0 of a frame.
REQ-011 Port: out_last  output  1  out_bit is element N-1 of a frame.
REQ-012 Port: out_idx  output  clog2(N+1)  element index of out_bit, 0..N-1.

Function
REQ-013 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-014 Storage SHALL be one N-bit shift register (active frame) plus one N-bit holding buffer with a valid flag.
REQ-015 in_ready SHALL equal NOT(holding buffer valid), combinationally.
REQ-016 FSM states SHALL be IDLE (out_valid=0) and SHIFT (out_valid=1).
REQ-017 IDLE, on accept: in_data loads directly into the shift register, idx=0, next state SHIFT. out_valid=1 and out_first=1 in the cycle after the accept edge. The holding buffer stays empty.
REQ-018 SHIFT, on accept: in_data SHALL go to the holding buffer.
REQ-019 Bit order SHALL be LSB first; out_bit SHALL equal shift register bit 0; out_idx SHALL equal idx.
REQ-020 On transfer with idx<N-1, the register SHALL shift right by one and idx SHALL increment.
REQ-021 out_ready=0 in SHIFT SHALL hold out_bit, out_idx, out_first and out_last unchanged.
REQ-022 On transfer with idx=N-1, the frame ends:
- holding buffer valid: it moves into the shift register, idx=0, state stays SHIFT, buffer cleared; zero bubble cycles.
- else, accept on the same edge: in_data loads directly, idx=0, state stays SHIFT.
- else: state returns to IDLE.
REQ-023 Buffer full, last-bit transfer and in_valid=1 all on one edge: no accept occurs; the buffer drains; in_ready rises the next cycle.
REQ-024 out_first SHALL be (idx==0) AND out_valid; out_last SHALL be (idx==N-1) AND out_valid; for N=1 both are high on every valid beat.
REQ-025 in_data SHALL be sampled only at accept; later changes to in_data SHALL not affect frames in flight.

Reset
REQ-026 When rst=0 the block SHALL immediately go to: state IDLE, shift register 0, idx 0, holding buffer empty; out_valid=0, out_bit=0, out_first=0, out_last=0, out_idx=0, in_ready=1.
REQ-027 Reset mid-frame SHALL discard the partial frame and any buffered frame; no completion beat.
REQ-028 The first accept SHALL be possible on the first rising edge after rst returns to 1.

Structure
REQ-029 The FSM state enum (IDLE, SHIFT) and the frame-length helper (kernal*kernal, index width) SHALL live in the shared pim_pkg package.
REQ-030 The holding buffer SHALL be a sub-module kernel_hold_buf (N-bit data, valid flag, load/drain) instantiated once; all other logic stays in kernel_serializer.

Verification
REQ-031 kernal=3, in_data=9'b100000000, out_ready=1 -> eight beats with out_bit=0, then out_bit=1 with out_last=1, out_idx=8, then out_valid=0.
REQ-032 Words 9'h0A5 then 9'h15A offered back-to-back with out_ready=1 -> 18 contiguous valid beats (bits 1,0,1,0,0,1,0,1,0 then 0,1,0,1,1,0,1,0,1) and out_first on beats 0 and 9.
REQ-033 9'h1FF, out_ready=0 for cycles 3-6 of the frame -> out_bit=1 and out_idx held during the stall; nine transfers total; in_ready stays 1 while the buffer is empty.
REQ-034 Third word offered while one frame is shifting and one is buffered -> in_ready=0 until the buffered frame starts; no word lost or duplicated.
REQ-035 rst=0 at out_idx=4 -> out_valid=0 immediately; after release, a new word 9'h001 serializes from out_idx=0 with out_bit=1 on the first beat.
